// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcodes and the datapath mux/ALUOp select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Bounded wait counter for memory handshakes; flags a timeout on the cycle the
// count would reach TIMEOUT while the memory is still not ready.
module mips_mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign timeout = en && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || timeout) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences each instruction
// and drives mux selects, ALUOp and all PC/IR/register/memory enables.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_e state_q;
  state_e state_d;
  logic   pc_write;
  logic   branch;
  logic   wait_en;
  logic   wait_clr;
  logic   timeout;

  assign wait_en  = is_wait_state(state_q);
  assign wait_clr = !wait_en || mem_ready;
  assign state_o  = state_q;

  mips_mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wait_en),
    .clr     (wait_clr),
    .timeout (timeout)
  );

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        // Ready wins over timeout; a timeout refetches from the unchanged PC.
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYPE;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (branch & zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected output
// vectors are queued as stimulus is driven and compared when sampled.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed vector layout:
  // [20:17] state, 16 pc_en, 15 ir_write, 14 iord, 13 mem_read, 12 mem_write,
  // 11 mem_to_reg, 10 reg_dst, 9 reg_write, 8 alu_src_a, [7:6] alu_src_b,
  // [5:4] alu_op, [3:2] pc_src, 1 illegal_op, 0 mem_err
  logic [20:0] obs;
  assign obs = {state_o, pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                illegal_op, mem_err};

  localparam logic [20:0] PCEN = 21'h1 << 16;
  localparam logic [20:0] IRW  = 21'h1 << 15;
  localparam logic [20:0] ILL  = 21'h1 << 1;
  localparam logic [20:0] MERR = 21'h1;

  logic [20:0] sb[$];

  mips_multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .mem_err(mem_err),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output table for each state, written from the state listing.
  function automatic logic [20:0] base(input logic [3:0] st);
    logic pe, irw, io, mr, mw, m2r, rd, rw, sa, il, me;
    logic [1:0] sbx, op, ps;
    {pe, irw, io, mr, mw, m2r, rd, rw, sa, il, me} = '0;
    sbx = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mr = 1; sbx = 2'b01; end
      4'd2:  sbx = 2'b11;
      4'd3:  begin sa = 1; sbx = 2'b10; end
      4'd4:  begin mr = 1; io = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; io = 1; end
      4'd7:  begin sa = 1; op = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 1; op = 2'b01; ps = 2'b01; end
      4'd10: begin sa = 1; sbx = 2'b10; op = 2'b11; end
      4'd11: rw = 1;
      4'd12: begin pe = 1; ps = 2'b10; end
      default: ;
    endcase
    return {st, pe, irw, io, mr, mw, m2r, rd, rw, sa, sbx, op, ps, il, me};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Drives one cycle's inputs and queues the expected outputs for that cycle.
  task automatic drive(input logic mr, input logic z, input logic [5:0] op,
                       input logic [20:0] exp);
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    sb.push_back(exp);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (obs !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, 21'h0);
    end
    #2;
    rst_n = 1'b1;
    drive(1, 0, 6'h00, base(4'd0));
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, e); end
    @(negedge clk);
    drive(0, 0, 6'h00, base(4'd1));
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_fetch: got %h want %h", obs, e); end
    $display("[TB] reset: outputs zero during reset, IDLE then FETCH");
  endtask

  task automatic test_rtype();
    logic [20:0] e;
    logic [3:0] seq[6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 0, 6'h00, base(seq[i]) | ((seq[i] == 4'd1) ? (PCEN | IRW) : 21'h0));
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL rtype[%0d]: got %h want %h", i, obs, e); end
    end
    $display("[TB] rtype: IDLE FETCH DECODE EXEC ALUWB FETCH");
  endtask

  task automatic test_lw_wait();
    logic [20:0] e;
    logic [3:0] seq[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
    logic       rdy[9] = '{1, 1, 1, 1, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      drive(rdy[i], 0, 6'h23, base(seq[i]) | ((seq[i] == 4'd1) ? (PCEN | IRW) : 21'h0));
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL lw_wait[%0d]: got %h want %h", i, obs, e); end
    end
    $display("[TB] lw: MEMRD held 4 cycles then MEMWB");
  endtask

  task automatic test_beq(input logic z);
    logic [20:0] e;
    logic [3:0] seq[5] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      e = base(seq[i]);
      if (seq[i] == 4'd1) e = e | PCEN | IRW;
      if (seq[i] == 4'd9 && z) e = e | PCEN;
      drive(1, z, 6'h04, e);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL beq_z%0b[%0d]: got %h want %h", z, i, obs, e); end
    end
    $display("[TB] beq zero=%0b: branch pc_en=%0b", z, z);
  endtask

  task automatic test_fetch_timeout();
    logic [20:0] e;
    do_reset();
    drive(0, 0, 6'h08, base(4'd0));
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL tmo_idle: got %h want %h", obs, e); end
    // Two consecutive timeouts: the second proves the counter restarts.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      drive(0, 0, 6'h08, base(4'd1) | ((i % 16 == 0) ? MERR : 21'h0));
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL tmo_fetch[%0d]: got %h want %h", i, obs, e); end
    end
    $display("[TB] fetch timeout: mem_err on cycles 16 and 32");
    do_reset();
    drive(0, 0, 6'h08, base(4'd0));
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL edge_idle: got %h want %h", obs, e); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 16)       drive(0, 0, 6'h08, base(4'd1));
      else if (i == 16) drive(1, 0, 6'h08, base(4'd1) | PCEN | IRW);
      else if (i == 17) drive(0, 0, 6'h08, base(4'd2));
      else if (i == 18) drive(0, 0, 6'h08, base(4'd10));
      else if (i == 19) drive(0, 0, 6'h08, base(4'd11));
      else              drive(0, 0, 6'h08, base(4'd1));
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL edge_ready[%0d]: got %h want %h", i, obs, e); end
    end
    $display("[TB] fetch ready on cycle 16: success, addi sequence follows");
  endtask

  task automatic test_illegal_and_jump();
    logic [20:0] e;
    logic [3:0] seq[7]  = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd12, 4'd1};
    logic [5:0] ops[7]  = '{6'h3F, 6'h3F, 6'h3F, 6'h02, 6'h02, 6'h02, 6'h02};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      e = base(seq[i]);
      if (seq[i] == 4'd1) e = e | PCEN | IRW;
      if (i == 2) e = e | ILL;
      drive(1, 0, ops[i], e);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL illegal_jump[%0d]: got %h want %h", i, obs, e); end
    end
    $display("[TB] illegal 0x3F pulses illegal_op, then jump");
  endtask

  task automatic test_reset_in_memwr();
    logic [20:0] e;
    logic [3:0] seq[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      e = base(seq[i]);
      if (seq[i] == 4'd1) e = e | PCEN | IRW;
      drive((i < 4), 0, 6'h2B, e);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL sw_path[%0d]: got %h want %h", i, obs, e); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_write !== 1'b0 || obs !== 21'h0) begin
      n_fail++;
      $display("FAIL async_reset: mem_write %b obs %h want 0", mem_write, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 6'h2B, base(4'd0));
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs, e); end
    @(negedge clk);
    drive(1, 0, 6'h2B, base(4'd1) | PCEN | IRW);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL post_reset_fetch: got %h want %h", obs, e); end
    $display("[TB] reset in MEMWR: mem_write dropped asynchronously");
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_fetch_timeout();
    test_illegal_and_jump();
    test_reset_in_memwr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
